// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package fetch_pkg;

   localparam int unsigned FETCH_DEPTH_DEF    = 4;
   localparam logic [31:0] FETCH_RESET_PC_DEF = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   function automatic int unsigned fetch_ptr_w(input int unsigned depth);
      return (depth > 32'd1) ? $clog2(depth) : 32'd1;
   endfunction

   // Occupancy counters need one extra bit to represent a completely full queue.
   function automatic int unsigned fetch_cnt_w(input int unsigned depth);
      return fetch_ptr_w(depth) + 32'd1;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetched {instr, pc} entries.
// A clear empties the queue in one cycle and overrides any push or pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = FETCH_DEPTH_DEF
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          clear,
   input  logic                          push,
   input  fetch_entry_t                  push_entry,
   input  logic                          pop,
   output fetch_entry_t                  head,
   output logic [fetch_cnt_w(DEPTH)-1:0] count
);

   localparam int unsigned   PW      = fetch_ptr_w(DEPTH);
   localparam int unsigned   CW      = fetch_cnt_w(DEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push_s, do_pop_s;

   // Next pointers, occupancy and storage contents.
   always_comb begin
      do_push_s = push & ~clear;
      do_pop_s  = pop & ~clear & (count_q != '0);
      mem_d     = mem_q;
      if (do_push_s) begin
         mem_d[wr_ptr_q] = push_entry;
      end else begin
         mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
      end
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         wr_ptr_d = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
         rd_ptr_d = do_pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
         case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // State registers; storage needs no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: PC sequencing, request credit and post-redirect discard.
// Optional macro FETCH_PERF_EN adds the empty_stall_cnt performance counter output.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH    = FETCH_DEPTH_DEF,
   parameter logic [31:0] RESET_PC = FETCH_RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        rstn,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] instr,
   output logic [31:0] pc,
`ifdef FETCH_PERF_EN
   output logic [31:0] pc_plus4,
   output logic [31:0] empty_stall_cnt
`else
   output logic [31:0] pc_plus4
`endif
);

   localparam int unsigned   CW      = fetch_cnt_w(DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW:0]   CREDIT  = (CW+1)'(DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [CW-1:0] stored_s;
   logic          accept_s, rsp_s, push_s, pop_s;
   logic [31:0]   rsp_pc_s;
   fetch_entry_t  push_entry_s, head_s;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rstn       (rstn),
      .clear      (redirect),
      .push       (push_s),
      .push_entry (push_entry_s),
      .pop        (pop_s),
      .head       (head_s),
      .count      (stored_s)
   );

   // Request credit, response routing and next PC / counter values.
   always_comb begin
      if (rstn && !redirect && (({1'b0, stored_s} + {1'b0, inflight_q}) < CREDIT)) begin
         imem_req = 1'b1;
      end else begin
         imem_req = 1'b0;
      end
      accept_s = imem_req & imem_gnt;
      // A response with nothing outstanding is a leftover from before reset.
      rsp_s    = imem_rvalid & (inflight_q != '0);
      push_s   = rsp_s & (discard_q == '0) & ~redirect;
      // Live requests are contiguous and end at pc_q-4, so the oldest is pc_q - 4*inflight.
      rsp_pc_s     = pc_q - 32'({inflight_q, 2'b00});
      push_entry_s = '{instr: imem_rdata, pc: rsp_pc_s};
      pc_d = accept_s ? (pc_q + 32'd4) : pc_q;
      case ({accept_s, rsp_s})
         2'b10:   inflight_d = inflight_q + CNT_ONE;
         2'b01:   inflight_d = inflight_q - CNT_ONE;
         default: inflight_d = inflight_q;
      endcase
      if (redirect) begin
         pc_d      = redirect_pc;
         discard_d = inflight_d;
      end else if (rsp_s && (discard_q != '0)) begin
         discard_d = discard_q - CNT_ONE;
      end else begin
         discard_d = discard_q;
      end
   end

   // Fetch PC and outstanding-request bookkeeping.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         pc_q       <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

   // Head entry toward decode, zeroed when the queue is empty.
   always_comb begin
      out_valid = (stored_s != '0);
      if (out_valid) begin
         instr    = head_s.instr;
         pc       = head_s.pc;
         pc_plus4 = head_s.pc + 32'd4;
      end else begin
         instr    = 32'd0;
         pc       = 32'd0;
         pc_plus4 = 32'd0;
      end
   end

   assign pop_s     = out_valid & out_ready;
   assign imem_addr = pc_q;

`ifdef FETCH_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of cycles where decode is starved outside reset and redirect.
   always_comb begin
      if (!out_valid && !redirect && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         stall_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign empty_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
   import fetch_pkg::*;

   localparam int unsigned DEPTH      = 4;
   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_W = 32'hFFFF_FFF8;

   logic        clk;
   logic        rstn, gnt, rvalid, redirect, out_ready;
   logic [31:0] rdata, redirect_pc;
   logic        imem_req, out_valid;
   logic [31:0] imem_addr, instr, pc, pc_plus4;
   logic        gnt_w, rvalid_w, out_ready_w, redirect_w;
   logic [31:0] rdata_w, redirect_pc_w;
   logic        imem_req_w, out_valid_w;
   logic [31:0] imem_addr_w, instr_w, pc_w, pc_plus4_w;
`ifdef FETCH_PERF_EN
   logic [31:0] empty_stall_cnt, empty_stall_cnt_w;
`endif

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rstn(rstn), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(gnt), .imem_rvalid(rvalid), .imem_rdata(rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .instr(instr), .pc(pc),
`ifdef FETCH_PERF_EN
      .empty_stall_cnt(empty_stall_cnt),
`endif
      .pc_plus4(pc_plus4)
   );

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC_W)) dut_w (
      .clk(clk), .rstn(rstn), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
      .imem_gnt(gnt_w), .imem_rvalid(rvalid_w), .imem_rdata(rdata_w),
      .redirect(redirect_w), .redirect_pc(redirect_pc_w),
      .out_valid(out_valid_w), .out_ready(out_ready_w),
      .instr(instr_w), .pc(pc_w),
`ifdef FETCH_PERF_EN
      .empty_stall_cnt(empty_stall_cnt_w),
`endif
      .pc_plus4(pc_plus4_w)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
   typedef struct { bit dead; logic [31:0] pc; } req_t;

   ent_t        m_q[$];
   req_t        m_out[$];
   logic [31:0] m_pc = RESET_PC;
   logic [31:0] m_stall = 32'd0;
   int          n_vec = 0;
   int          n_miss = 0;
   bit          w_on = 1'b0;
   int          w_k = 0;
   logic        acc_w = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit has_out();
      return m_out.size() > 0;
   endfunction

   // One clock: apply inputs, compare against the model, advance the model.
   task automatic drive(input bit chk, input bit rst_v, input bit g, input bit rv,
                        input bit rdy, input bit redir, input logic [31:0] rpc);
      bit   m_req, pre_valid;
      req_t r;
      rstn = rst_v; gnt = g; rvalid = rv; out_ready = rdy;
      redirect = redir; redirect_pc = rpc; rdata = $urandom;
      #1;
      m_req = rst_v && !redir && ((m_q.size() + m_out.size()) < DEPTH);
      pre_valid = m_q.size() > 0;
      if (chk) begin
         check_val("imem_req", imem_req, m_req);
         if (m_req) check_val("imem_addr", imem_addr, m_pc);
         check_val("out_valid", out_valid, pre_valid);
         if (pre_valid) begin
            check_val("instr", instr, m_q[0].instr);
            check_val("pc", pc, m_q[0].pc);
            check_val("pc_plus4", pc_plus4, m_q[0].pc + 32'd4);
         end
`ifdef FETCH_PERF_EN
         check_val("stall_cnt_model", empty_stall_cnt, m_stall);
`endif
      end
      if (w_on && w_k < 4) begin
         check_val("w_req", imem_req_w, 1'b1);
         check_val("w_addr", imem_addr_w, RESET_PC_W + 32'(4 * w_k));
         if (w_k >= 2) begin
            check_val("w_pc", pc_w, RESET_PC_W + 32'(4 * (w_k - 2)));
            check_val("w_pc_plus4", pc_plus4_w, RESET_PC_W + 32'(4 * (w_k - 1)));
         end
         w_k++;
      end
      acc_w = imem_req_w && gnt_w;
      if (!rst_v) begin
         m_q.delete();
         m_out.delete();
         m_pc = RESET_PC;
         m_stall = 32'd0;
      end else begin
         if (!redir && rdy && m_q.size() > 0) void'(m_q.pop_front());
         if (rv && m_out.size() > 0) begin
            r = m_out.pop_front();
            if (!r.dead && !redir) m_q.push_back('{instr: rdata, pc: r.pc});
         end
         if (m_req && g) begin
            m_out.push_back('{dead: 1'b0, pc: m_pc});
            m_pc = m_pc + 32'd4;
         end
         if (redir) begin
            m_q.delete();
            foreach (m_out[i]) m_out[i].dead = 1'b1;
            m_pc = rpc;
         end
         if (!pre_valid && !redir && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      end
      @(posedge clk);
      @(negedge clk);
      rvalid_w = acc_w;
      rdata_w  = $urandom;
   endtask

   initial begin
      bit          g, rv, rdy, rd;
      logic [31:0] rpc;
      rstn = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'd0;
      redirect = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
      gnt_w = 1'b1; rvalid_w = 1'b0; rdata_w = 32'd0; out_ready_w = 1'b1;
      redirect_w = 1'b0; redirect_pc_w = 32'd0;

      // Reset, with responses arriving that must be ignored.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      repeat (2) drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
      check_val("rst_out_valid", out_valid, 1'b0);
      check_val("rst_instr", instr, 32'd0);
      check_val("rst_pc", pc, 32'd0);
      check_val("rst_pc_plus4", pc_plus4, 32'd0);
      check_val("rst_addr", imem_addr, RESET_PC);
      w_on = 1'b1;

      // Streaming at one instruction per cycle.
      repeat (8) drive(1'b1, 1'b1, 1'b1, has_out(), 1'b1, 1'b0, 32'd0);

      // Decode back-pressure: credit runs out, head held stable.
      repeat (8) drive(1'b1, 1'b1, 1'b1, has_out(), 1'b0, 1'b0, 32'd0);
      check_val("full_req", imem_req, 1'b0);
      check_val("full_valid", out_valid, 1'b1);
      repeat (6) drive(1'b1, 1'b1, 1'b1, has_out(), 1'b1, 1'b0, 32'd0);

      // Drain, put 3 in flight, redirect to 0x100.
      repeat (8) drive(1'b1, 1'b1, 1'b0, has_out(), 1'b1, 1'b0, 32'd0);
      repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
      repeat (10) drive(1'b1, 1'b1, 1'b1, has_out(), 1'b1, 1'b0, 32'd0);

      // Back-to-back redirects with responses in the redirect cycles.
      drive(1'b1, 1'b1, 1'b1, has_out(), 1'b1, 1'b1, 32'h0000_0200);
      drive(1'b1, 1'b1, 1'b1, has_out(), 1'b1, 1'b1, 32'h0000_0300);
      repeat (10) drive(1'b1, 1'b1, 1'b1, has_out(), 1'b1, 1'b0, 32'd0);

      // Random traffic, including redirects near the top of the address space.
      repeat (1500) begin
         g   = ($urandom_range(0, 3) != 0);
         rv  = has_out() && ($urandom_range(0, 2) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         rd  = ($urandom_range(0, 19) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
         drive(1'b1, 1'b1, g, rv, rdy, rd, rpc);
      end

      // Reset with 2 stored and 2 in flight; late responses after release.
      repeat (8) drive(1'b1, 1'b1, 1'b0, has_out(), 1'b1, 1'b0, 32'd0);
      repeat (4) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      repeat (2) drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
      for (int k = 0; k < 10; k++) drive(1'b1, 1'b1, 1'b0, (k < 2), 1'b1, 1'b0, 32'd0);
      check_val("late_out_valid", out_valid, 1'b0);
      check_val("late_addr", imem_addr, RESET_PC);
`ifdef FETCH_PERF_EN
      check_val("stall_cnt_10", empty_stall_cnt, 32'd10);
`endif
      repeat (6) drive(1'b1, 1'b1, 1'b1, has_out(), 1'b1, 1'b0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
